wifi_tx_frame_fifo: RTL
=======================

// Module: wifi_tx_frame_fifo
// PURPOSE
//  Parametrised frame-aware FIFO between the WIFI TX scrambler/encoder output and the mapper.
//  Buffers DW-bit symbols and meters them out on read request.
//  Tracks the frame lifecycle (load, drain, tail) and drives finished/last_sym to the TX controller.
//  Adds to the 1-bit mapper buffer: width/depth generics, full/empty/level, sticky error flags, configurable tail length.
// PARAMETERS
//  DW           1   data width, bits per entry
//  AW           14  address width; depth = 2**AW entries
//  TAIL_CYCLES  8   idle cycles after the last read before finished reasserts (>=1)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     reset, asynchronous, active-low
//  we         in   1     write strobe; data_in captured when accepted
//  data_in    in   DW    write data
//  full       out  1     count == 2**AW (combinational from regs)
//  re         in   1     read request from mapper
//  data_out   out  DW    read data, registered, valid when valid_out=1
//  valid_out  out  1     data_out valid, 1 cycle after accepted read
//  empty      out  1     count == 0
//  level      out  AW+1  current entry count
//  finished   out  1     1 = no frame in progress
//  last_sym   out  1     1 = FIFO drained, tail countdown running
//  overflow   out  1     sticky: write attempted while full
//  underflow  out  1     sticky: read attempted while empty
//  flush      in   1     only with WIFI_TX_FIFO_FLUSH_EN
// BEHAVIOUR
//  Reset values: data_out=0, valid_out=0, level=0, empty=1, full=0, finished=1, last_sym=0, overflow=0, underflow=0; state=IDLE.
//  Pointers are AW+1 bits and wrap modulo 2**(AW+1); level = wr_ptr - rd_ptr.
//  Read accept rd_acc = re & ~empty; data_out <= mem[rd_ptr], valid_out <= 1 next cycle, else valid_out <= 0.
//  Write accept wr_acc = we & (~full | rd_acc).
//    Write into a full FIFO is accepted only with a same-cycle read; otherwise dropped and overflow set.
//  Read while empty is ignored (valid_out=0) and sets underflow; simultaneous write does not bypass into same-cycle read.
//  Simultaneous accepted read+write: level unchanged. Sticky flags clear only on reset (or flush).
//  FSM (registered finished/last_sym):
//    IDLE : finished=1. wr_acc -> LOAD.
//    LOAD : finished=1. we=0 -> DRAIN; finished<=0.
//    DRAIN: finished=0. empty & ~we -> TAIL; last_sym<=1, tcnt<=0.
//    TAIL : last_sym=1. Each cycle with valid_out=0: tcnt++.
//           At tcnt==TAIL_CYCLES-1 -> IDLE; finished<=1, last_sym<=0.
//           wr_acc -> DRAIN; last_sym<=0, tcnt<=0.
//  tcnt width = $clog2(TAIL_CYCLES)+1. Async reset mid-frame returns to IDLE; memory contents are not cleared.
//  Memory: no reset, one write port and one read port, inferable as block RAM.
// CONFIGURATION
//  WIFI_TX_FIFO_FLUSH_EN defined: flush port exists; flush=1 synchronously zeroes both pointers, valid_out, flags, tcnt.
//    Flush sets state=IDLE, finished=1, last_sym=0.
//    Flush has priority over we/re in the same cycle.
//  Undefined: no flush port; only reset clears the FIFO.
// TESTING
//  1. Reset, then write 4 words 0x1..0x4 (DW=4) -> level=4; finished stays 1 until we falls, then 0 next cycle.
//  2. re held 4 cycles -> valid_out high cycles 2..5 with data 1,2,3,4; empty=1 after the last read.
//  3. After drain, re=0 -> last_sym=1; finished=1 exactly TAIL_CYCLES(8) cycles later; last_sym=0.
//  4. AW=2: 5 writes -> full=1 after 4; 5th write sets overflow; level=4.
//     Then read+write on the same cycle while full -> level stays 4 and both are accepted.
//  5. re on empty FIFO -> underflow=1, valid_out=0; write during TAIL -> last_sym=0, state DRAIN, finished=0.
//  6. reset low mid-DRAIN -> all outputs at reset values next edge.
//     With FLUSH_EN, flush+we same cycle -> level=0.

Source files
------------

// File: rtl/wifi_tx_frame_fifo_if.sv
// Handshake/status bundle between the TX encoder, the symbol FIFO and the mapper.
// The flush signal exists only when WIFI_TX_FIFO_FLUSH_EN is defined.
interface wifi_tx_frame_fifo_if #(
    parameter int DW = 1,
    parameter int AW = 14
);
    logic          we;
    logic [DW-1:0] data_in;
    logic          full;
    logic          re;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          empty;
    logic [AW:0]   level;
    logic          finished;
    logic          last_sym;
    logic          overflow;
    logic          underflow;
`ifdef WIFI_TX_FIFO_FLUSH_EN
    logic          flush;
`endif

    modport master (
        output we, data_in, re,
`ifdef WIFI_TX_FIFO_FLUSH_EN
        output flush,
`endif
        input  full, data_out, valid_out, empty, level,
        input  finished, last_sym, overflow, underflow
    );

    modport slave (
        input  we, data_in, re,
`ifdef WIFI_TX_FIFO_FLUSH_EN
        input  flush,
`endif
        output full, data_out, valid_out, empty, level,
        output finished, last_sym, overflow, underflow
    );
endinterface

// File: rtl/wifi_tx_frame_fifo.sv
// Frame-aware symbol FIFO between the WIFI TX encoder and the mapper.
// Build macro WIFI_TX_FIFO_FLUSH_EN adds a synchronous flush input.
//
// state | meaning
// IDLE  | no frame in progress, finished=1
// LOAD  | frame being written, finished held at 1 until the write burst ends
// DRAIN | frame in flight, finished=0
// TAIL  | FIFO drained, last_sym=1 while the tail count runs
module wifi_tx_frame_fifo #(
    parameter int DW          = 1,
    parameter int AW          = 14,
    parameter int TAIL_CYCLES = 8
) (
    input logic                 clk,
    input logic                 reset,
    wifi_tx_frame_fifo_if.slave bus
);
    localparam int            TW        = $clog2(TAIL_CYCLES) + 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TAIL_CYCLES - 1);
    localparam logic [AW:0]   DEPTH     = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] TAIL  = 2'd3;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          finished_q, finished_d;
    logic          last_sym_q, last_sym_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [AW:0]   level;
    logic          empty, full, rd_acc, wr_acc;

    always_comb begin
        level  = wr_ptr_q - rd_ptr_q;
        empty  = (level == '0);
        full   = (level == DEPTH);
        rd_acc = bus.re & ~empty;
        wr_acc = bus.we & (~full | rd_acc);

        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        data_out_d  = data_out_q;
        if (rd_acc) data_out_d = mem[rd_ptr_q[AW-1:0]];
        valid_out_d = rd_acc;
        overflow_d  = overflow_q | (bus.we & ~wr_acc);
        underflow_d = underflow_q | (bus.re & empty);

        state_d    = state_q;
        finished_d = finished_q;
        last_sym_d = last_sym_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            IDLE: if (wr_acc) state_d = LOAD;
            LOAD: if (!bus.we) begin
                state_d    = DRAIN;
                finished_d = 1'b0;
            end
            DRAIN: if (empty && !bus.we) begin
                state_d    = TAIL;
                last_sym_d = 1'b1;
                tcnt_d     = '0;
            end
            TAIL: begin
                // A new write revives the frame even on the terminal tail cycle.
                if (wr_acc) begin
                    state_d    = DRAIN;
                    last_sym_d = 1'b0;
                    tcnt_d     = '0;
                end else if (!valid_out_q) begin
                    if (tcnt_q == TCNT_LAST) begin
                        state_d    = IDLE;
                        finished_d = 1'b1;
                        last_sym_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef WIFI_TX_FIFO_FLUSH_EN
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            valid_out_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            tcnt_d      = '0;
            state_d     = IDLE;
            finished_d  = 1'b1;
            last_sym_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            finished_q  <= 1'b1;
            last_sym_q  <= 1'b0;
            state_q     <= IDLE;
            tcnt_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            finished_q  <= finished_d;
            last_sym_q  <= last_sym_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.level     = level;
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.finished  = finished_q;
    assign bus.last_sym  = last_sym_q;
endmodule
